// File: rtl/mmio_pkg.sv
// mmio_pkg: shared I/O window base, register offsets and STATUS bit positions
package mmio_pkg;
  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
  localparam logic [3:0] OFF_R0 = 4'h0;
  localparam logic [3:0] OFF_R1 = 4'h4;
  localparam logic [3:0] OFF_ST = 4'h8;
  localparam int ST_EMPTY = 8;
  localparam int ST_FULL = 9;
  localparam int ST_OVF = 16;
endpackage

// File: rtl/mmio_if.sv
// mmio_if: core store/load bus, data-memory side, drain tick and display outputs; slave = bridge, master = environment
interface mmio_if;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        tick_i;
  logic [31:0] r0_o;
  logic [31:0] r1_o;
  modport slave(input mem_write_i, addr_i, wdata_i, dmem_rdata_i, tick_i,
                output rdata_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, r0_o, r1_o);
  modport master(output mem_write_i, addr_i, wdata_i, dmem_rdata_i, tick_i,
                 input rdata_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, r0_o, r1_o);
endinterface

// File: rtl/disp_wfifo.sv
// disp_wfifo: synchronous FIFO; ports clk, reset, i_push/i_pop/i_din in, o_dout/o_full/o_empty/o_count out; push when full accepted only with a same-cycle pop
module disp_wfifo #(
  parameter int DEPTH = 4,
  parameter int W = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: splits core accesses between data memory and a 16-byte I/O window (R0, R1, STATUS); ports clk, reset, mmio_if.slave bus
module mmio_bridge #(
  parameter logic [31:0] IO_BASE = mmio_pkg::IO_BASE,
  parameter int FIFO_DEPTH = 4
) (
  input logic   clk,
  input logic   reset,
  mmio_if.slave bus
);
  import mmio_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic          w_hit, w_push, w_pop, w_st_wr, w_full, w_empty;
  logic [3:0]    w_off;
  logic [32:0]   w_dout;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic          r_ovf;
  logic [31:0]   r_r0, r_r1;
  assign w_hit   = bus.addr_i[31:4] == IO_BASE[31:4];
  assign w_off   = bus.addr_i[3:0];
  assign w_push  = bus.mem_write_i & w_hit & (w_off == OFF_R0 | w_off == OFF_R1);
  assign w_st_wr = bus.mem_write_i & w_hit & w_off == OFF_ST;
  assign w_pop   = bus.tick_i & ~w_empty;
  assign bus.dmem_addr_o  = bus.addr_i;
  assign bus.dmem_wdata_o = bus.wdata_i;
  assign bus.dmem_we_o    = bus.mem_write_i & ~w_hit;
  assign bus.r0_o = r_r0;
  assign bus.r1_o = r_r1;
  disp_wfifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
    .clk(clk), .reset(reset), .i_push(w_push), .i_pop(w_pop),
    .i_din({w_off == OFF_R1, bus.wdata_i}), .o_dout(w_dout),
    .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );
  always_comb begin
    w_status = '0;
    w_status[4:0] = 5'(w_count);
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL] = w_full;
    w_status[ST_OVF] = r_ovf;
    bus.rdata_o = !w_hit ? bus.dmem_rdata_i :
                  w_off == OFF_R0 ? r_r0 :
                  w_off == OFF_R1 ? r_r1 :
                  w_off == OFF_ST ? w_status : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ovf <= 1'b0;
      r_r0  <= '0;
      r_r1  <= '0;
    end else begin
      if (w_st_wr) r_ovf <= 1'b0;
      else if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      if (w_pop & w_dout[32]) r_r1 <= w_dout[31:0];
      if (w_pop & ~w_dout[32]) r_r0 <= w_dout[31:0];
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: table-driven vectors plus directed multi-cycle sequences for mmio_bridge
module tb_mmio_bridge;
  localparam logic [31:0] A_R0 = 32'hFFFF_0000;
  localparam logic [31:0] A_R1 = 32'hFFFF_0004;
  localparam logic [31:0] A_ST = 32'hFFFF_0008;
  localparam logic [31:0] A_UN = 32'hFFFF_000C;
  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, drd;
    logic        tick;
    logic [31:0] e_rd;
    logic        e_we;
    logic [31:0] e_r0, e_r1;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t v[21];
  mmio_if bus();
  mmio_bridge dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic tk);
    bus.mem_write_i = we;
    bus.addr_i = a;
    bus.wdata_i = wd;
    bus.tick_i = tk;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic rd_st(input string n, input logic [31:0] e);
    drive(1'b0, A_ST, 32'h0, 1'b0);
    #1;
    chk(n, bus.rdata_o, e);
  endtask
  function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] wd, logic [31:0] drd, logic tk,
                              logic [31:0] erd, logic ewe, logic [31:0] er0, logic [31:0] er1);
    vec_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.drd = drd; t.tick = tk;
    t.e_rd = erd; t.e_we = ewe; t.e_r0 = er0; t.e_r1 = er1;
    return t;
  endfunction
  initial begin
    v[0]  = mk(0, 32'h40, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0);
    v[1]  = mk(1, 32'h40, 32'h1234, 32'h11111111, 0, 32'h11111111, 1, 0, 0);
    v[2]  = mk(0, A_ST, 0, 0, 0, 32'h100, 0, 0, 0);
    v[3]  = mk(1, A_R0, 32'hAA, 0, 0, 0, 0, 0, 0);
    v[4]  = mk(1, A_R1, 32'hBB, 0, 0, 0, 0, 0, 0);
    v[5]  = mk(0, A_ST, 0, 0, 0, 32'h2, 0, 0, 0);
    v[6]  = mk(0, A_R0, 0, 0, 1, 0, 0, 0, 0);
    v[7]  = mk(0, A_R0, 0, 0, 0, 32'hAA, 0, 32'hAA, 0);
    v[8]  = mk(0, A_ST, 0, 0, 0, 32'h1, 0, 32'hAA, 0);
    v[9]  = mk(0, A_R1, 0, 0, 1, 0, 0, 32'hAA, 0);
    v[10] = mk(0, A_R1, 0, 0, 0, 32'hBB, 0, 32'hAA, 32'hBB);
    v[11] = mk(0, A_ST, 0, 0, 0, 32'h100, 0, 32'hAA, 32'hBB);
    v[12] = mk(0, A_UN, 0, 32'h77, 0, 0, 0, 32'hAA, 32'hBB);
    v[13] = mk(1, A_UN, 32'h5, 0, 0, 0, 0, 32'hAA, 32'hBB);
    v[14] = mk(0, A_ST, 0, 0, 0, 32'h100, 0, 32'hAA, 32'hBB);
    v[15] = mk(1, 32'hFFFF0010, 0, 32'h5A5A, 0, 32'h5A5A, 1, 32'hAA, 32'hBB);
    v[16] = mk(1, 32'hFFFEFFFC, 0, 32'hC3, 0, 32'hC3, 1, 32'hAA, 32'hBB);
    v[17] = mk(1, A_R0, 32'h77, 0, 1, 32'hAA, 0, 32'hAA, 32'hBB);
    v[18] = mk(0, A_ST, 0, 0, 0, 32'h1, 0, 32'hAA, 32'hBB);
    v[19] = mk(0, A_ST, 0, 0, 1, 32'h1, 0, 32'hAA, 32'hBB);
    v[20] = mk(0, A_R0, 0, 0, 0, 32'h77, 0, 32'h77, 32'hBB);
    drive(0, 32'h0, 32'h0, 0);
    bus.dmem_rdata_i = 32'h0;
    #12;
    chk("reset_r0", bus.r0_o, 32'h0);
    chk("reset_r1", bus.r1_o, 32'h0);
    rd_st("reset_status", 32'h100);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 21; i++) begin
      drive(v[i].we, v[i].addr, v[i].wdata, v[i].tick);
      bus.dmem_rdata_i = v[i].drd;
      #1;
      chk($sformatf("v%0d_rdata", i), bus.rdata_o, v[i].e_rd);
      chk($sformatf("v%0d_dmem_we", i), 32'(bus.dmem_we_o), 32'(v[i].e_we));
      chk($sformatf("v%0d_dmem_addr", i), bus.dmem_addr_o, v[i].addr);
      chk($sformatf("v%0d_dmem_wdata", i), bus.dmem_wdata_o, v[i].wdata);
      chk($sformatf("v%0d_r0", i), bus.r0_o, v[i].e_r0);
      chk($sformatf("v%0d_r1", i), bus.r1_o, v[i].e_r1);
      cyc();
    end
    for (int i = 1; i <= 5; i++) begin
      drive(1, A_R0, 32'(i), 0);
      cyc();
    end
    rd_st("overflow_status", 32'h10204);
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h100, 0, 1);
      cyc();
    end
    drive(0, 32'h100, 0, 0);
    #1;
    chk("drain4_r0", bus.r0_o, 32'h4);
    rd_st("drained_sticky", 32'h10100);
    drive(1, A_ST, 32'hDEAD, 0);
    cyc();
    rd_st("ovf_cleared", 32'h100);
    for (int i = 0; i < 4; i++) begin
      drive(1, A_R0, 32'(10 + i), 0);
      cyc();
    end
    rd_st("full_status", 32'h204);
    drive(1, A_R1, 32'h9, 1);
    cyc();
    rd_st("push_pop_full", 32'h204);
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h100, 0, 1);
      cyc();
    end
    drive(0, 32'h100, 0, 0);
    #1;
    chk("pp_full_r1", bus.r1_o, 32'h9);
    chk("pp_full_r0", bus.r0_o, 32'd13);
    rd_st("pp_full_empty", 32'h100);
    drive(1, A_R0, 32'h7, 0);
    cyc();
    drive(0, 32'h100, 0, 1);
    cyc();
    drive(1, A_R1, 32'h1, 0);
    cyc();
    drive(1, A_R1, 32'h2, 0);
    cyc();
    drive(0, 32'h100, 0, 0);
    #1;
    chk("pre_reset_r0", bus.r0_o, 32'h7);
    rd_st("pre_reset_status", 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_r0", bus.r0_o, 32'h0);
    chk("async_reset_r1", bus.r1_o, 32'h9 & 32'h0);
    rd_st("async_reset_status", 32'h100);
    drive(1, A_R0, 32'h55, 1);
    cyc();
    #2;
    reset = 1'b0;
    drive(0, 32'h100, 0, 0);
    #1;
    chk("held_reset_r0", bus.r0_o, 32'h0);
    rd_st("held_reset_status", 32'h100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
